sram_resp: RTL and testbench

- Responder (slave) end of the CPU's SRAM-style memory interface.
- Accepts en/wen/addr/wdata requests and returns rdata exactly one cycle later.
- Backs the requests with a word-addressed synchronous RAM plus a small memory-mapped register window: a free-running timer, an LED register and a scratch register.
- One instance serves the data port of the CPU top. A second instance, with wen tied to 0, may serve the instruction port.

---
 rtl/sram_resp_if.sv | 38 +++
 rtl/sram_resp.sv | 172 +++++++++++++++++
 tb/tb_sram_resp.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sram_resp_if.sv
// -----------------------------------------------------------------------------
// sram_resp_if
//
// SRAM-style request/response bus between the CPU (master) and a memory
// responder (slave). There is no handshake. A request is presented with
// sram_en=1 for one cycle, and its read data comes back on sram_rdata in the
// following cycle.
//
// Signals:
//   sram_en     master->slave  request valid this cycle
//   sram_wen    master->slave  byte write enables (0 = read)
//   sram_addr   master->slave  byte address (bits [1:0] ignored)
//   sram_wdata  master->slave  write data
//   sram_rdata  slave->master  read data, valid the cycle after the request
// -----------------------------------------------------------------------------
interface sram_resp_if;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   modport master (
      output sram_en,
      output sram_wen,
      output sram_addr,
      output sram_wdata,
      input  sram_rdata
   );

   modport slave (
      input  sram_en,
      input  sram_wen,
      input  sram_addr,
      input  sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/sram_resp.sv
// -----------------------------------------------------------------------------
// sram_resp
//
// Responder end of the CPU's SRAM-style memory interface. Each request is
// served from a word-addressed synchronous RAM or from a small MMIO register
// window. Read data is returned exactly one cycle after the request. All
// reads are read-first: a request sees the contents from before its own edge.
//
// MMIO window (selected when addr[31:16] == MMIO_HI), byte offsets:
//   0x0000 TIMER   32-bit free-running counter; writes load it for one cycle
//   0x0004 LED     16-bit register; only byte lanes 0-1 are writable
//   0x0008 SCRATCH 32-bit general-purpose register
//   others         read as 0; writes are ignored
//
// Ports:
//   clk    input   clock; all state updates on the rising edge
//   reset  input   synchronous, active-high reset
//   bus    slave   request/response bus (sram_resp_if.slave)
//   led    output  current LED register value
//   timer  output  current timer value (debug)
// -----------------------------------------------------------------------------
module sram_resp #(
   parameter int          ADDR_W  = 12,
   parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
   input  logic          clk,
   input  logic          reset,
   sram_resp_if.slave    bus,
   output logic [15:0]   led,
   output logic [31:0]   timer
);

   localparam int DEPTH = 1 << ADDR_W;

   // MMIO register word offsets (byte offset >> 2)
   localparam logic [13:0] OFF_TIMER   = 14'h0000;
   localparam logic [13:0] OFF_LED     = 14'h0001;
   localparam logic [13:0] OFF_SCRATCH = 14'h0002;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------

   // Overlay the enabled byte lanes of wd onto old.
   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  wen);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (wen[b]) res[8*b +: 8] = wd[8*b +: 8];
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]  mem [DEPTH];

   logic [31:0]  timer_q,   timer_d;
   logic [15:0]  led_q,     led_d;
   logic [31:0]  scratch_q, scratch_d;
   logic [31:0]  mmio_rd_q, mmio_rd_d;   // registered MMIO read data
   logic         sel_mmio_q, sel_mmio_d; // which source drives sram_rdata
   logic [31:0]  ram_rd_q;               // registered RAM read data

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   logic              mmio_sel;
   logic [ADDR_W-1:0] word_idx;
   logic [13:0]       mmio_off;
   logic              req_wr;
   logic              ram_rd;
   logic              ram_we;
   logic              timer_we;
   logic              led_we;
   logic              scratch_we;
   logic [1:0]        unused_addr_lsb;

   assign mmio_sel = (bus.sram_addr[31:16] == MMIO_HI);
   // Upper bits are dropped on purpose: out-of-range addresses alias into RAM.
   assign word_idx = bus.sram_addr[ADDR_W+1:2];
   assign mmio_off = bus.sram_addr[15:2];
   assign unused_addr_lsb = bus.sram_addr[1:0];

   // A request presented during reset is dropped entirely.
   assign req_wr     = bus.sram_en && (bus.sram_wen != 4'b0000) && !reset;
   assign ram_rd     = bus.sram_en && !mmio_sel && !reset;
   assign ram_we     = req_wr && !mmio_sel;
   assign timer_we   = req_wr && mmio_sel && (mmio_off == OFF_TIMER);
   assign led_we     = req_wr && mmio_sel && (mmio_off == OFF_LED);
   assign scratch_we = req_wr && mmio_sel && (mmio_off == OFF_SCRATCH);

   // ---------------------------------------------------------------------------
   // MMIO next state and read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      timer_d    = timer_q + 32'd1;
      led_d      = led_q;
      scratch_d  = scratch_q;
      mmio_rd_d  = mmio_rd_q;
      sel_mmio_d = sel_mmio_q;

      // A timer write replaces the increment for that cycle.
      if (timer_we) timer_d = lane_merge(timer_q, bus.sram_wdata, bus.sram_wen);

      // LED is 16 bits wide, so only lanes 0 and 1 can be written.
      if (led_we) begin
         if (bus.sram_wen[0]) led_d[7:0]  = bus.sram_wdata[7:0];
         if (bus.sram_wen[1]) led_d[15:8] = bus.sram_wdata[15:8];
      end

      if (scratch_we) scratch_d = lane_merge(scratch_q, bus.sram_wdata, bus.sram_wen);

      // Read-first: capture pre-edge register contents for any request.
      if (bus.sram_en) begin
         sel_mmio_d = mmio_sel;
         if (mmio_sel) begin
            case (mmio_off)
               OFF_TIMER:   mmio_rd_d = timer_q;
               OFF_LED:     mmio_rd_d = {16'h0000, led_q};
               OFF_SCRATCH: mmio_rd_d = scratch_q;
               default:     mmio_rd_d = 32'h0000_0000;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // MMIO registers and response select
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q    <= 32'h0000_0000;
         led_q      <= 16'h0000;
         scratch_q  <= 32'h0000_0000;
         // Selecting the zeroed MMIO register forces rdata to 0 after reset
         // without having to reset the RAM output register.
         mmio_rd_q  <= 32'h0000_0000;
         sel_mmio_q <= 1'b1;
      end else begin
         timer_q    <= timer_d;
         led_q      <= led_d;
         scratch_q  <= scratch_d;
         mmio_rd_q  <= mmio_rd_d;
         sel_mmio_q <= sel_mmio_d;
      end
   end

   // ---------------------------------------------------------------------------
   // RAM: synchronous read-first, per-byte write, contents not reset
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ram_rd) ram_rd_q <= mem[word_idx];
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.sram_wen[b]) mem[word_idx][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Neither source register changes while en=0, so rdata holds on idle cycles.
   assign bus.sram_rdata = sel_mmio_q ? mmio_rd_q : ram_rd_q;
   assign led            = led_q;
   assign timer          = timer_q;

endmodule

// File: tb/tb_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_sram_resp
//
// Directed bench for sram_resp. Each step drives one request for one clock
// cycle and samples the outputs 1 time unit after the rising edge. At that
// point sram_rdata carries the response to the request just issued.
// -----------------------------------------------------------------------------
module tb_sram_resp;

   logic        clk;
   logic        reset;
   logic [15:0] led;
   logic [31:0] timer;

   int total = 0;
   int bad   = 0;

   sram_resp_if bus ();

   sram_resp #(
      .ADDR_W  (12),
      .MMIO_HI (16'hbfaf)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .led   (led),
      .timer (timer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] A_TIMER   = 32'hbfaf_0000;
   localparam logic [31:0] A_LED     = 32'hbfaf_0004;
   localparam logic [31:0] A_SCRATCH = 32'hbfaf_0008;
   localparam logic [31:0] A_UNMAP   = 32'hbfaf_000c;

   // Drive one cycle of request, then sample just after the edge.
   task automatic step(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
      bus.sram_en    = en;
      bus.sram_wen   = wen;
      bus.sram_addr  = addr;
      bus.sram_wdata = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.sram_en    = 1'b0;
      bus.sram_wen   = 4'h0;
      bus.sram_addr  = 32'h0;
      bus.sram_wdata = 32'h0;

      // Reset state
      step(1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      check("reset_rdata", bus.sram_rdata, 32'h0);
      check("reset_led",   {16'h0, led},   32'h0);
      check("reset_timer", timer,          32'h0);

      // Timer counts from 0 in the first cycle after reset
      reset = 1'b0;
      step(1'b0, 4'h0, 32'h0, 32'h0);
      check("timer_cycle1", timer, 32'd1);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b1, 4'h0, A_TIMER, 32'h0);
      check("timer_read5", bus.sram_rdata, 32'd5);

      // Timer load, then increment and wrap
      step(1'b1, 4'hf, A_TIMER, 32'hffff_fffe);
      check("timer_loaded", timer, 32'hffff_fffe);
      step(1'b1, 4'h0, A_TIMER, 32'h0);
      check("timer_rd_fe", bus.sram_rdata, 32'hffff_fffe);
      step(1'b1, 4'h0, A_TIMER, 32'h0);
      check("timer_rd_ff", bus.sram_rdata, 32'hffff_ffff);
      step(1'b1, 4'h0, A_TIMER, 32'h0);
      check("timer_wrap", bus.sram_rdata, 32'h0);

      // RAM full-word write, then back-to-back read
      step(1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678);
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("ram_word", bus.sram_rdata, 32'h1234_5678);

      // Byte lanes; the write itself returns the old word
      step(1'b1, 4'b0101, 32'h0000_0010, 32'haabb_ccdd);
      check("ram_wr_readfirst", bus.sram_rdata, 32'h1234_5678);
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("ram_lanes", bus.sram_rdata, 32'h12bb_56dd);

      // Hold while en=0; wen without en does nothing
      step(1'b0, 4'hf, 32'h0000_0010, 32'hffff_ffff);
      check("hold1", bus.sram_rdata, 32'h12bb_56dd);
      step(1'b0, 4'hf, 32'h0000_0010, 32'hffff_ffff);
      check("hold2", bus.sram_rdata, 32'h12bb_56dd);
      step(1'b0, 4'hf, 32'h0000_0010, 32'hffff_ffff);
      check("hold3", bus.sram_rdata, 32'h12bb_56dd);
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("wen_no_en", bus.sram_rdata, 32'h12bb_56dd);

      // Aliasing of out-of-range address onto word 4
      step(1'b1, 4'hf, 32'h0000_4010, 32'hcafe_f00d);
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("alias", bus.sram_rdata, 32'hcafe_f00d);

      // An MMIO write must not reach RAM
      step(1'b1, 4'hf, 32'hbfaf_0010, 32'hffff_ffff);
      check("mmio_unmapped_wr_rd", bus.sram_rdata, 32'h0);
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("mmio_not_ram", bus.sram_rdata, 32'hcafe_f00d);

      // LED
      step(1'b1, 4'hf, A_LED, 32'hdead_beef);
      check("led_out", {16'h0, led}, 32'h0000_beef);
      step(1'b1, 4'h0, A_LED, 32'h0);
      check("led_read", bus.sram_rdata, 32'h0000_beef);
      step(1'b1, 4'b1100, A_LED, 32'h1234_0000);
      check("led_upper_ignored", {16'h0, led}, 32'h0000_beef);
      step(1'b1, 4'b0010, A_LED, 32'h0000_5a00);
      check("led_lane1", {16'h0, led}, 32'h0000_5aef);

      // SCRATCH
      step(1'b1, 4'hf, A_SCRATCH, 32'h1122_3344);
      step(1'b1, 4'b1000, A_SCRATCH, 32'haa00_0000);
      check("scratch_wr_readfirst", bus.sram_rdata, 32'h1122_3344);
      step(1'b1, 4'h0, A_SCRATCH, 32'h0);
      check("scratch_top", bus.sram_rdata, 32'haa22_3344);

      // Unmapped offset
      step(1'b1, 4'hf, A_UNMAP, 32'h5555_5555);
      step(1'b1, 4'h0, A_UNMAP, 32'h0);
      check("unmapped_read", bus.sram_rdata, 32'h0);

      // Put a known value back in rdata before the reset
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("pre_reset_rd", bus.sram_rdata, 32'hcafe_f00d);

      // Reset mid-operation with a coincident write
      reset = 1'b1;
      step(1'b1, 4'hf, 32'h0000_0010, 32'h0bad_beef);
      check("rst_rdata", bus.sram_rdata, 32'h0);
      check("rst_led",   {16'h0, led},   32'h0);
      check("rst_timer", timer,          32'h0);
      reset = 1'b0;
      step(1'b1, 4'h0, A_TIMER, 32'h0);
      check("rst_timer_read", bus.sram_rdata, 32'h0);
      step(1'b1, 4'h0, A_LED, 32'h0);
      check("rst_led_read", bus.sram_rdata, 32'h0);
      step(1'b1, 4'h0, A_SCRATCH, 32'h0);
      check("rst_scratch_read", bus.sram_rdata, 32'h0);
      step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("rst_write_dropped", bus.sram_rdata, 32'hcafe_f00d);
      step(1'b0, 4'h0, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
